inst_loader: RTL and testbench

- Upstream feeder of the MIPS pipeline top.
- Assembles bytes from the debug UART receiver into INST_SZ-bit instruction words.
- Drives the pipeline's instruction-memory write port (i_write / i_instruction) until a HALT word or memory capacity is reached, then reports load completion to the debug unit.

---
 rtl/inst_loader.sv | 135 +++++++++++++
 tb/tb_inst_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Assembles big-endian UART bytes into instruction words and streams them into the
// pipeline's instruction memory until a HALT word or capacity is reached.
module inst_loader #(
  parameter int                   INST_SZ     = 32,
  parameter int                   BYTE_SZ     = 8,
  parameter int                   MEM_DEPTH   = 256,
  parameter int                   CNT_SZ      = 9,
  parameter logic [INST_SZ-1:0]   HALT_INST   = 32'hFFFF_FFFF,
  parameter int                   TIMEOUT_CYC = 100000,
  parameter int                   TIMER_SZ    = 17
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_req,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic [CNT_SZ-1:0]  o_inst_count,
  output logic               o_loading,
  output logic               o_load_done,
  output logic               o_timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Only the three most recent bytes need to be held; the fourth comes straight off the bus.
  localparam int SHIFT_W = INST_SZ - BYTE_SZ;

  localparam logic [TIMER_SZ-1:0] TIMER_LAST = TIMER_SZ'(TIMEOUT_CYC - 1);
  localparam logic [CNT_SZ-1:0]   CNT_FULL   = CNT_SZ'(MEM_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [TIMER_SZ-1:0] timer_q, timer_d;
  logic [CNT_SZ-1:0]  inst_count_q, inst_count_d;
  logic [INST_SZ-1:0] instruction_q, instruction_d;
  logic               write_q, write_d;
  logic               loading_q, loading_d;
  logic               load_done_q, load_done_d;
  logic               timeout_q, timeout_d;
  logic [INST_SZ-1:0] word;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    timer_d       = timer_q;
    inst_count_d  = inst_count_q;
    instruction_d = instruction_q;
    write_d       = 1'b0;
    timeout_d     = 1'b0;
    word          = {shift_q, i_rx_data};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_load_req) begin
          state_d      = ST_RECEIVE;
          byte_cnt_d   = 2'd0;
          shift_d      = '0;
          timer_d      = '0;
          inst_count_d = '0;
        end
      end
      ST_RECEIVE: begin
        if (i_rx_done) begin
          shift_d = {shift_q[SHIFT_W-BYTE_SZ-1:0], i_rx_data};
          timer_d = '0;
          if (byte_cnt_q == 2'd3) begin
            instruction_d = word;
            write_d       = 1'b1;
            inst_count_d  = inst_count_q + 1'b1;
            byte_cnt_d    = 2'd0;
            if ((word == HALT_INST) || (inst_count_d == CNT_FULL)) begin
              state_d = ST_DONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q != 2'd0) begin
          // A stalled partial word is thrown away; completed words are untouched.
          if (timer_q == TIMER_LAST) begin
            byte_cnt_d = 2'd0;
            shift_d    = '0;
            timer_d    = '0;
            timeout_d  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    loading_d   = (state_d == ST_RECEIVE);
    load_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      shift_q       <= '0;
      timer_q       <= '0;
      inst_count_q  <= '0;
      instruction_q <= '0;
      write_q       <= 1'b0;
      loading_q     <= 1'b0;
      load_done_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      timer_q       <= timer_d;
      inst_count_q  <= inst_count_d;
      instruction_q <= instruction_d;
      write_q       <= write_d;
      loading_q     <= loading_d;
      load_done_q   <= load_done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign o_instruction = instruction_q;
  assign o_write       = write_q;
  assign o_inst_count  = inst_count_q;
  assign o_loading     = loading_q;
  assign o_load_done   = load_done_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: small depth and timeout so capacity and idle-discard paths are reachable.
module tb_inst_loader;

  localparam int CNT_SZ = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_done = 1'b0;
  logic [31:0]       o_instruction;
  logic              o_write;
  logic [CNT_SZ-1:0] o_inst_count;
  logic              o_loading;
  logic              o_load_done;
  logic              o_timeout;

  inst_loader #(
    .INST_SZ(32), .BYTE_SZ(8), .MEM_DEPTH(4), .CNT_SZ(CNT_SZ),
    .HALT_INST(32'hFFFF_FFFF), .TIMEOUT_CYC(10), .TIMER_SZ(17)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_load_req(load_req),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_instruction(o_instruction), .o_write(o_write), .o_inst_count(o_inst_count),
    .o_loading(o_loading), .o_load_done(o_load_done), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic [CNT_SZ-1:0] cnt; } sb_t;
  typedef struct { logic [31:0] word; int exp_cnt; logic exp_done; } vec_t;

  sb_t  sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   tout_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_timeout) tout_cnt++;
    if (o_write) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got instr 0x%0h count %0d expected no write at %0t",
                 o_instruction, o_inst_count, $time);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("write_instr", o_instruction, e.word);
        check("write_count", 32'(o_inst_count), 32'(e.cnt));
      end
    end
  end

  // All drive tasks start and end at 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_wr, input int cnt, input int gap);
    sb_t e;
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    if (gap > 0) step(gap);
    send_byte(w[15:8]);
    if (expect_wr) begin
      e.word = w;
      e.cnt  = CNT_SZ'(cnt);
      sbq.push_back(e);
    end
    send_byte(w[7:0]);
  endtask

  // The write belonging to the last byte must have appeared by the next falling edge.
  task automatic drain(input string name);
    @(negedge clk);
    #1;
    check(name, 32'(sbq.size()), 32'd0);
    step(1);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"},   o_instruction, 32'd0);
    check({tag, "_write"},   32'(o_write), 32'd0);
    check({tag, "_count"},   32'(o_inst_count), 32'd0);
    check({tag, "_loading"}, 32'(o_loading), 32'd0);
    check({tag, "_done"},    32'(o_load_done), 32'd0);
    check({tag, "_timeout"}, 32'(o_timeout), 32'd0);
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{32'h2001_0005, 1, 1'b0};
    tbl[1] = '{32'h1234_5678, 2, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 3, 1'b1};

    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    step(1);

    // Bytes in IDLE must not produce writes.
    send_word(32'hDEAD_BEEF, 1'b0, 0, 0);
    drain("idle_nowrite");
    check("idle_loading", 32'(o_loading), 32'd0);

    // Load request with a coincident strobe: the byte is ignored.
    load_req = 1'b1;
    rx_data  = 8'h55;
    rx_done  = 1'b1;
    step(1);
    load_req = 1'b0;
    rx_done  = 1'b0;
    check("start_loading", 32'(o_loading), 32'd1);
    check("start_count", 32'(o_inst_count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      send_word(tbl[i].word, 1'b1, tbl[i].exp_cnt, 0);
      drain("tbl_wr_timing");
      check("tbl_count", 32'(o_inst_count), 32'(tbl[i].exp_cnt));
      check("tbl_done", 32'(o_load_done), 32'(tbl[i].exp_done));
      check("tbl_loading", 32'(o_loading), 32'(!tbl[i].exp_done));
    end

    // DONE ignores further bytes.
    send_word(32'h0BAD_0BAD, 1'b0, 0, 0);
    drain("done_nowrite");
    check("done_count_hold", 32'(o_inst_count), 32'd3);

    // Reload from DONE with eight back-to-back bytes.
    pulse_load();
    check("reload_done", 32'(o_load_done), 32'd0);
    check("reload_loading", 32'(o_loading), 32'd1);
    check("reload_count", 32'(o_inst_count), 32'd0);
    check("reload_instr_hold", o_instruction, 32'hFFFF_FFFF);
    send_word(32'hA1A2_A3A4, 1'b1, 1, 0);
    send_word(32'hB1B2_B3B4, 1'b1, 2, 0);
    drain("b2b_wr");
    check("b2b_count", 32'(o_inst_count), 32'd2);
    check("b2b_done", 32'(o_load_done), 32'd0);

    // Capacity of four words ends the load.
    send_word(32'hC1C2_C3C4, 1'b1, 3, 0);
    send_word(32'hD1D2_D3D4, 1'b1, 4, 0);
    drain("depth_wr");
    check("depth_count", 32'(o_inst_count), 32'd4);
    check("depth_done", 32'(o_load_done), 32'd1);
    check("depth_loading", 32'(o_loading), 32'd0);

    // Partial word discarded after ten idle cycles.
    pulse_load();
    send_byte(8'h11);
    send_byte(8'h22);
    step(9);
    check("tout_early", 32'(o_timeout), 32'd0);
    step(1);
    check("tout_pulse", 32'(o_timeout), 32'd1);
    step(1);
    check("tout_single", 32'(o_timeout), 32'd0);
    check("tout_count", 32'(o_inst_count), 32'd0);
    check("tout_loading", 32'(o_loading), 32'd1);
    send_word(32'hAABB_CCDD, 1'b1, 1, 0);
    drain("after_tout_wr");
    check("after_tout_instr", o_instruction, 32'hAABB_CCDD);

    // A byte on the would-be timeout cycle is accepted instead.
    send_word(32'h0102_0304, 1'b1, 2, 9);
    drain("tout_race_wr");
    check("tout_race_total", 32'(tout_cnt), 32'd1);
    check("tout_race_count", 32'(o_inst_count), 32'd2);

    // Asynchronous reset in the middle of a word.
    send_byte(8'h77);
    send_byte(8'h66);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    step(1);
    rst = 1'b0;
    step(1);
    send_word(32'h5566_7788, 1'b0, 0, 0);
    drain("post_reset_nowrite");
    check("post_reset_loading", 32'(o_loading), 32'd0);
    check("post_reset_count", 32'(o_inst_count), 32'd0);

    step(2);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
